rvfi_check_sequencer: RTL and testbench

- Formal-harness scheduler that drives a riscv-formal checker's reset, trig and check inputs from one saturating cycle counter.
- Replaces ad-hoc cycle compares in testbenches.
- Adds a retire-anchored trigger mode: trig lands on the first retired instruction at or after a cycle threshold, and check follows at a fixed distance.
- Sits between the RVFI wrapper outputs and the checker instance.

---
 rtl/rvfi_seq_pkg.sv | 34 +++
 rtl/rvfi_check_sequencer_if.sv | 30 +++
 rtl/rvfi_sat_counter.sv | 33 +++
 rtl/rvfi_check_sequencer.sv | 152 +++++++++++++++
 tb/tb_rvfi_check_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_seq_pkg.sv
// Shared types and helpers for the RVFI check sequencer: FSM state encoding,
// retire popcount and the cycle-parameter legality rule.
package rvfi_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_RUN   = 3'd1,
    S_ARMED = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Widest retire vector the popcount helper accepts.
  localparam int unsigned POP_MAX_W = 32;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // Reset window must close before arming, trig before check, and check
  // must land strictly below the saturated cycle value.
  function automatic bit params_legal(input int rst_c, input int trig_c,
                                      input int chk_c, input int cnt_w);
    if (cnt_w < 1 || cnt_w > 30) return 1'b0;
    return (rst_c >= 1) && (rst_c < trig_c) && (trig_c < chk_c) &&
           (chk_c < ((1 << cnt_w) - 1));
  endfunction

endpackage

// File: rtl/rvfi_check_sequencer_if.sv
// Bundle between the RVFI wrapper / harness and the check sequencer.
// master drives the retire/halt strobes, slave is the sequencer.
interface rvfi_check_sequencer_if #(
  parameter int NRET  = 1,
  parameter int CNT_W = 8
);
  import rvfi_seq_pkg::*;

  logic [NRET-1:0]  rvfi_valid;
  logic [NRET-1:0]  rvfi_halt;
  logic             chk_reset;
  logic             chk_trig;
  logic             chk_check;
  logic [CNT_W-1:0] cycle;
  logic [CNT_W-1:0] retire_cnt;
  state_t           state;
  logic             done;
  logic             timeout;

  modport master (
    output rvfi_valid, rvfi_halt,
    input  chk_reset, chk_trig, chk_check, cycle, retire_cnt, state, done, timeout
  );

  modport slave (
    input  rvfi_valid, rvfi_halt,
    output chk_reset, chk_trig, chk_check, cycle, retire_cnt, state, done, timeout
  );

endinterface

// File: rtl/rvfi_sat_counter.sv
// Saturating up-counter: adds an arbitrary increment each cycle, clamps at
// all-ones instead of wrapping. Synchronous active-low reset and clear.
module rvfi_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic [WIDTH-1:0] inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  // Sum one bit wider than the counter so a carry out means "clamp".
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  // Count register: reset and clear both return to zero.
  always_ff @(posedge clock) begin
    if (!resetn || clr) begin
      count <= '0;
    end else begin
      count <= sat_add(count, inc);
    end
  end

  assign sat = &count;

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Drives a riscv-formal checker's reset/trig/check from one saturating cycle
// counter. Mode 0 fires trig/check at fixed cycles; mode 1 arms at
// TRIG_CYCLE and anchors trig on the first retire, with check a fixed
// distance later, or gives up (timeout) on halt or cycle saturation.
module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int RESET_CYCLES   = 1,
  parameter int TRIG_CYCLE     = 10,
  parameter int CHECK_CYCLE    = 15,
  parameter int TRIG_ON_RETIRE = 0,
  parameter int NRET           = 1,
  parameter int CNT_W          = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  rvfi_check_sequencer_if.slave  bus
);

  if (!params_legal(RESET_CYCLES, TRIG_CYCLE, CHECK_CYCLE, CNT_W)) begin : g_param_err
    $error("rvfi_check_sequencer: need 1 <= RESET_CYCLES < TRIG_CYCLE < CHECK_CYCLE < 2^CNT_W-1");
  end
  if (NRET < 1 || NRET > POP_MAX_W) begin : g_nret_err
    $error("rvfi_check_sequencer: NRET out of range");
  end

  localparam bit               MODE_RET = (TRIG_ON_RETIRE != 0);
  localparam logic [CNT_W-1:0] RST_C    = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIG_C   = CNT_W'(TRIG_CYCLE);
  localparam logic [CNT_W-1:0] ARM_C    = CNT_W'(TRIG_CYCLE - 1);
  localparam logic [CNT_W-1:0] CHK_C    = CNT_W'(CHECK_CYCLE);
  localparam logic [CNT_W-1:0] DLT_LAST = CNT_W'(CHECK_CYCLE - TRIG_CYCLE - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cycle, delta, retire_cnt;
  logic [CNT_W-1:0] retire_inc;
  logic             cycle_sat, delta_sat, retire_sat;
  logic             unused_sat;
  logic             chk_reset, chk_trig, chk_check;
  logic             timeout, set_timeout;
  logic             any_valid, any_halt;

  assign any_valid = |bus.rvfi_valid;
  assign any_halt  = |bus.rvfi_halt;
  assign chk_reset = (cycle < RST_C);

  // Retires inside the checker reset window are not counted.
  assign retire_inc = chk_reset ? '0 : CNT_W'(popcount(POP_MAX_W'(bus.rvfi_valid)));

  rvfi_sat_counter #(.WIDTH(CNT_W)) u_cycle (
    .clock (clock),
    .resetn(resetn),
    .clr   (1'b0),
    .inc   (CNT_W'(1)),
    .count (cycle),
    .sat   (cycle_sat)
  );

  // Distance from trig; held at zero outside S_WAIT so it starts fresh.
  rvfi_sat_counter #(.WIDTH(CNT_W)) u_delta (
    .clock (clock),
    .resetn(resetn),
    .clr   (state != S_WAIT),
    .inc   (CNT_W'(1)),
    .count (delta),
    .sat   (delta_sat)
  );

  rvfi_sat_counter #(.WIDTH(CNT_W)) u_retire (
    .clock (clock),
    .resetn(resetn),
    .clr   (1'b0),
    .inc   (retire_inc),
    .count (retire_cnt),
    .sat   (retire_sat)
  );

  assign unused_sat = delta_sat ^ retire_sat;

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_RESET;
    end else begin
      state <= state_nx;
    end
  end

  // Sticky timeout flag, raised on the give-up transition out of S_ARMED.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      timeout <= 1'b0;
    end else if (set_timeout) begin
      timeout <= 1'b1;
    end
  end

  // Next-state logic; in S_ARMED a retire beats a simultaneous halt.
  always_comb begin
    state_nx    = state;
    set_timeout = 1'b0;
    case (state)
      S_RESET: if (cycle == RST_LAST) state_nx = S_RUN;
      S_RUN:   if (cycle == ARM_C) state_nx = MODE_RET ? S_ARMED : S_WAIT;
      S_ARMED: begin
        if (any_valid) begin
          state_nx = S_WAIT;
        end else if (any_halt || cycle_sat) begin
          state_nx    = S_DONE;
          set_timeout = 1'b1;
        end
      end
      S_WAIT: begin
        if (MODE_RET ? (delta == DLT_LAST) : (cycle == CHK_C)) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_RESET;
    endcase
  end

  // Output decode: trig/check pulses only from ARMED/WAIT, so never in reset.
  always_comb begin
    chk_trig  = 1'b0;
    chk_check = 1'b0;
    case (state)
      S_ARMED: chk_trig = any_valid;
      S_WAIT: begin
        if (MODE_RET) begin
          chk_check = (delta == DLT_LAST);
        end else begin
          chk_trig  = (cycle == TRIG_C);
          chk_check = (cycle == CHK_C);
        end
      end
      default: begin
        chk_trig  = 1'b0;
        chk_check = 1'b0;
      end
    endcase
  end

  assign bus.chk_reset  = chk_reset;
  assign bus.chk_trig   = chk_trig;
  assign bus.chk_check  = chk_check;
  assign bus.cycle      = cycle;
  assign bus.retire_cnt = retire_cnt;
  assign bus.state      = state;
  assign bus.done       = (state == S_DONE);
  assign bus.timeout    = timeout;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Bench for rvfi_check_sequencer: three instances (mode 0 / 8-bit, mode 1 /
// 8-bit, mode 1 / 5-bit) share clock, reset and a 2-channel retire trace.
// Each reset epoch is checked cycle by cycle against an event-level model.
module tb_rvfi_check_sequencer;
  import rvfi_seq_pkg::*;

  localparam int R = 2;
  localparam int T = 10;
  localparam int C = 15;
  localparam int D = C - T;
  localparam int NEVER = 1000000;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  rvfi_check_sequencer_if #(.NRET(2), .CNT_W(8)) if0 ();
  rvfi_check_sequencer_if #(.NRET(2), .CNT_W(8)) if1 ();
  rvfi_check_sequencer_if #(.NRET(2), .CNT_W(5)) if2 ();

  rvfi_check_sequencer #(.RESET_CYCLES(R), .TRIG_CYCLE(T), .CHECK_CYCLE(C),
    .TRIG_ON_RETIRE(0), .NRET(2), .CNT_W(8)) dut0 (.clock(clock), .resetn(resetn), .bus(if0.slave));
  rvfi_check_sequencer #(.RESET_CYCLES(R), .TRIG_CYCLE(T), .CHECK_CYCLE(C),
    .TRIG_ON_RETIRE(1), .NRET(2), .CNT_W(8)) dut1 (.clock(clock), .resetn(resetn), .bus(if1.slave));
  rvfi_check_sequencer #(.RESET_CYCLES(R), .TRIG_CYCLE(T), .CHECK_CYCLE(C),
    .TRIG_ON_RETIRE(1), .NRET(2), .CNT_W(5)) dut2 (.clock(clock), .resetn(resetn), .bus(if2.slave));

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] tr_v [512];
  logic [1:0] tr_h [512];
  int cur_len;

  int m_mode [3] = '{0, 1, 1};
  int m_cw   [3] = '{8, 8, 5};
  int e_trig [3];
  int e_chk  [3];
  int e_stop [3];
  int e_end  [3];
  int m_ret  [3];
  int obs_trig [3];
  int obs_chk  [3];
  logic obs_to [3];

  typedef struct {
    int         len;
    bit         early_v;
    bit         all_v;
    int         v_at;
    logic [1:0] v_val;
    int         h_at;
    bit         abort;
    int         exp_trig0;
    int         exp_trig1;
    int         exp_chk1;
    bit         exp_to1;
    bit         exp_to2;
  } vec_t;

  vec_t tbl [7];

  function automatic int pop2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic check(input string nm, input int d, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d k=%0d: got %0d expected %0d", nm, d, k, act, exp);
    end
  endtask

  // Derive the epoch's event cycles from the trace: fixed cycles in mode 0,
  // first retire at/after T (or halt / saturation) in mode 1.
  task automatic plan_events(input int d);
    int mx;
    mx = (1 << m_cw[d]) - 1;
    e_trig[d] = NEVER; e_chk[d] = NEVER; e_stop[d] = NEVER; e_end[d] = NEVER;
    if (m_mode[d] == 0) begin
      e_trig[d] = T; e_chk[d] = C; e_end[d] = C;
    end else begin
      for (int c = T; c < cur_len; c++) begin
        if (tr_v[c] != 2'b00) begin
          e_trig[d] = c; e_chk[d] = c + D; e_end[d] = c + D;
          break;
        end
        if (tr_h[c] != 2'b00 || c >= mx) begin
          e_stop[d] = c; e_end[d] = c;
          break;
        end
      end
    end
    m_ret[d] = 0; obs_trig[d] = -1; obs_chk[d] = -1; obs_to[d] = 1'b0;
  endtask

  task automatic check_dut(input int d, input int k, input logic rst_o, input logic trig_o,
                           input logic chk_o, input logic [7:0] cyc_o, input logic [7:0] ret_o,
                           input logic [2:0] st_o, input logic done_o, input logic to_o);
    int mx, ev;
    state_t st_e;
    mx = (1 << m_cw[d]) - 1;
    ev = (e_trig[d] != NEVER) ? e_trig[d] : e_stop[d];
    if (k < R) st_e = S_RESET;
    else if (k < T) st_e = S_RUN;
    else if (m_mode[d] == 0) st_e = (k <= C) ? S_WAIT : S_DONE;
    else if (k <= ev) st_e = S_ARMED;
    else if (e_trig[d] != NEVER && k <= e_chk[d]) st_e = S_WAIT;
    else st_e = S_DONE;
    check("chk_reset",  d, k, 32'(rst_o),  32'(k < R));
    check("chk_trig",   d, k, 32'(trig_o), 32'(k == e_trig[d]));
    check("chk_check",  d, k, 32'(chk_o),  32'(k == e_chk[d]));
    check("cycle",      d, k, 32'(cyc_o),  32'((k < mx) ? k : mx));
    check("retire_cnt", d, k, 32'(ret_o),  32'(m_ret[d]));
    check("done",       d, k, 32'(done_o), 32'(k > e_end[d]));
    check("timeout",    d, k, 32'(to_o),   32'(k > e_stop[d]));
    check("state",      d, k, 32'(st_o),   32'(st_e));
    if (trig_o === 1'b1 && obs_trig[d] < 0) obs_trig[d] = k;
    if (chk_o === 1'b1 && obs_chk[d] < 0) obs_chk[d] = k;
    obs_to[d] = to_o;
    if (k >= R) begin
      m_ret[d] = m_ret[d] + pop2(tr_v[k]);
      if (m_ret[d] > mx) m_ret[d] = mx;
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] h);
    if0.rvfi_valid = v; if0.rvfi_halt = h;
    if1.rvfi_valid = v; if1.rvfi_halt = h;
    if2.rvfi_valid = v; if2.rvfi_halt = h;
  endtask

  // One reset epoch: k counts cycles since release (cycle register == k).
  // With abort, resetn drops during the last cycle to restart mid-sequence.
  task automatic run_epoch(input int len, input bit abort);
    cur_len = len;
    if (resetn) begin
      resetn = 1'b0;
      @(posedge clock); #1;
    end
    resetn = 1'b1;
    for (int d = 0; d < 3; d++) plan_events(d);
    for (int k = 0; k < len; k++) begin
      drive(tr_v[k], tr_h[k]);
      if (abort && k == len - 1) resetn = 1'b0;
      @(negedge clock);
      check_dut(0, k, if0.chk_reset, if0.chk_trig, if0.chk_check, if0.cycle, if0.retire_cnt,
                if0.state, if0.done, if0.timeout);
      check_dut(1, k, if1.chk_reset, if1.chk_trig, if1.chk_check, if1.cycle, if1.retire_cnt,
                if1.state, if1.done, if1.timeout);
      check_dut(2, k, if2.chk_reset, if2.chk_trig, if2.chk_check, {3'b000, if2.cycle},
                {3'b000, if2.retire_cnt}, if2.state, if2.done, if2.timeout);
      @(posedge clock); #1;
    end
    drive(2'b00, 2'b00);
  endtask

  initial begin
    //            len  early all  v_at v_val  h_at abort trig0 trig1 chk1 to1 to2
    tbl[0] = '{ 22,  1,   0,  13, 2'b01, -1,  0,   10,   13,  18,  0,  0};
    tbl[1] = '{ 22,  0,   0,  -1, 2'b00, 12,  0,   10,   -1,  -1,  1,  1};
    tbl[2] = '{ 22,  0,   0,  12, 2'b01, 12,  0,   10,   12,  17,  0,  0};
    tbl[3] = '{ 40,  0,   0,  -1, 2'b00, -1,  0,   10,   -1,  -1,  0,  1};
    tbl[4] = '{ 13,  0,   0,  -1, 2'b00, -1,  1,   10,   -1,  -1,  0,  0};
    tbl[5] = '{ 22,  0,   0,  11, 2'b10, -1,  0,   10,   11,  16,  0,  0};
    tbl[6] = '{300,  0,   1,  -1, 2'b00, -1,  0,   10,   10,  15,  0,  0};

    drive(2'b00, 2'b00);
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < tbl[i].len; k++) begin
        if (tbl[i].all_v) tr_v[k] = 2'b11;
        else if (tbl[i].early_v && k >= 3 && k <= 9) tr_v[k] = 2'b11;
        else if (k == tbl[i].v_at) tr_v[k] = tbl[i].v_val;
        else tr_v[k] = 2'b00;
        tr_h[k] = (k == tbl[i].h_at) ? 2'b01 : 2'b00;
      end
      run_epoch(tbl[i].len, tbl[i].abort);
      check("vec_trig_mode0",  0, i, 32'(obs_trig[0]), 32'(tbl[i].exp_trig0));
      check("vec_trig_mode1",  1, i, 32'(obs_trig[1]), 32'(tbl[i].exp_trig1));
      check("vec_check_mode1", 1, i, 32'(obs_chk[1]),  32'(tbl[i].exp_chk1));
      check("vec_timeout",     1, i, 32'(obs_to[1]),   32'(tbl[i].exp_to1));
      check("vec_timeout",     2, i, 32'(obs_to[2]),   32'(tbl[i].exp_to2));
    end

    for (int e = 0; e < 8; e++) begin
      int len;
      bit abort;
      len = int'($urandom_range(20, 70));
      abort = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < len; k++) begin
        tr_v[k] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        tr_h[k] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      run_epoch(len, abort);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
